wb_forward_stage: RTL and testbench
===================================

WB_FORWARD_STAGE -- requirements
Module: wb_forward_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset  input  1  asynchronous, active-low; reset==0 clears all state immediately, independent of clk.
REQ-003 in_valid  input  1  EX stage holds a real instruction this cycle.
REQ-004 in_IR  input  16  EX instruction word; op = {IR[15:12],IR[1:0]}; regA = IR[11:9], regB = IR[8:6], regC = IR[5:3].
REQ-005 in_ALUOut, in_PlusOne  input  16 each  EX ALU result and EX PC+1.
REQ-006 in_CCRWrite  input  1  EX flag-write enable, active-low (0 = write); in_CCRWriteValue  input  2  {zero,carry}.
REQ-007 mem_rdata  input  16  data memory read data for the instruction in EX/MEM, valid in the same cycle.
REQ-008 stall  input  1  hold both stages; flush  input  1  squash the EX/MEM capture.
REQ-009 ex_mem_op, mem_wb_op  output  6 each; ex_mem_regA/B/C, mem_wb_regA/B/C  output  3 each; ex_mem_CCR_write, mem_wb_CCR_write  output  1 each (active-low).
REQ-010 SignalA, SignalB, SignalC, SignalG, SignalI, SignalJ, SignalK  output  16 each; SignalX, SignalY  output  2 each.
REQ-011 rf_write  output  1  active-low; rf_addr  output  3; rf_data  output  16.
REQ-012 CCR_Write_from_wb  output  1  active-low; CCRWriteValue_from_wb  output  2.

Function
REQ-013 The block SHALL hold two registered stages, EX/MEM and MEM/WB. Each stage stores: valid, IR, ALU result, PC+1, CCR-write flag, CCR value. MEM/WB additionally stores memory data.
REQ-014 On each posedge with stall==0, EX/MEM SHALL capture the in_* inputs, and MEM/WB SHALL capture EX/MEM plus mem_rdata. Both stages update on the same edge.
REQ-015 On a posedge with stall==1, both stages SHALL hold their contents. stall has priority over flush.
REQ-016 On a posedge with flush==1 and stall==0, EX/MEM SHALL load a bubble, and MEM/WB SHALL still advance normally.
REQ-017 A bubble (valid==0) SHALL present op = 6'b111111, regs = 3'b000, and CCR_write = 1. Its Signal outputs are don't-care; they drive 0.
REQ-018 Signal mapping:
- SignalA = EX/MEM ALU result.
- SignalB = MEM/WB ALU result.
- SignalC = MEM/WB memory data.
- SignalG = EX/MEM PC+1.
- SignalI = {EX/MEM IR[8:0], 7'b0}.
- SignalJ = {MEM/WB IR[8:0], 7'b0}.
- SignalK = MEM/WB PC+1.
- SignalX = EX/MEM CCR value.
- SignalY = MEM/WB CCR value.
REQ-019 Signal outputs SHALL be combinational from stage registers only, with zero latency.
REQ-020 Write-back destination:
- R-type ops (IR[15:12] in {0000, 0010}): regC.
- ADI (0001): regB.
- LHI (0011), LW (0100), JAL (1000), JLR (1001): regA.
- All other opcodes: no register write.
REQ-021 Write-back data SHALL be selected as follows:
- LW: memory data.
- LHI: SignalJ.
- JAL/JLR: SignalK.
- Otherwise: ALU result.
REQ-022 rf_write SHALL be 0 only when all of the following hold:
- MEM/WB is valid.
- The opcode writes a register per REQ-020.
- For ADC/ADZ/NDC/NDZ and ADD/NDU/ADI, mem_wb_CCR_write==0 (a suppressed conditional op does not write).
REQ-023 CCR_Write_from_wb SHALL equal mem_wb_CCR_write when MEM/WB is valid, and 1 otherwise. CCRWriteValue_from_wb SHALL equal SignalY.
REQ-024 Stage outputs SHALL reflect register contents only; in_* inputs never pass combinationally to any output.

Reset
REQ-025 While reset==0, both stages SHALL be bubbles. Outputs then read:
- op = 6'b111111, regs = 0, CCR_write = 1.
- All Signal outputs = 0.
- rf_write = 1, CCR_Write_from_wb = 1.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight instructions. The first valid capture occurs on the first posedge after reset returns to 1.

Verification
REQ-027 Reset test: reset=0 asynchronously between edges. Required: rf_write=1 and ex_mem_op=6'b111111 immediately, without waiting for a clock edge.
REQ-028 ADD r3,r1,r2 (IR=16'h0298), ALUOut=16'h0005, CCRWrite=0:
- Edge 1: SignalA=0005, ex_mem_regC=3.
- Edge 2: SignalB=0005, rf_write=0, rf_addr=3, rf_data=0005, CCR_Write_from_wb=0.
REQ-029 LW r4 (IR=16'h4800), mem_rdata=16'hBEEF during EX/MEM. Required after edge 2: SignalC=BEEF, rf_addr=4, rf_data=BEEF.
REQ-030 LHI r2,#9'h1FF (IR=16'h35FF). Required:
- After edge 1: SignalI=FF80.
- After edge 2: SignalJ=FF80 and rf_data=FF80.
REQ-031 Conditional and bubble cases:
- ADC with in_CCRWrite=1 reaches MEM/WB. Required: rf_write=1, CCR_Write_from_wb=1.
- stall=1 for 2 cycles. Required: outputs unchanged.
- flush=1 at the edge. Required: ex_mem_op=111111 while MEM/WB still advances.

Source files
------------

// File: rtl/wb_forward_stage.sv
// Two-stage EX/MEM -> MEM/WB pipeline tail with write-back decode and
// forwarding taps for the hazard unit. All outputs come from stage registers.
module wb_forward_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_IR,
  input  logic [15:0] in_ALUOut,
  input  logic [15:0] in_PlusOne,
  input  logic        in_CCRWrite,
  input  logic [1:0]  in_CCRWriteValue,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic [5:0]  ex_mem_op,
  output logic [2:0]  ex_mem_regA,
  output logic [2:0]  ex_mem_regB,
  output logic [2:0]  ex_mem_regC,
  output logic        ex_mem_CCR_write,
  output logic [5:0]  mem_wb_op,
  output logic [2:0]  mem_wb_regA,
  output logic [2:0]  mem_wb_regB,
  output logic [2:0]  mem_wb_regC,
  output logic        mem_wb_CCR_write,
  output logic [15:0] SignalA,
  output logic [15:0] SignalB,
  output logic [15:0] SignalC,
  output logic [15:0] SignalG,
  output logic [15:0] SignalI,
  output logic [15:0] SignalJ,
  output logic [15:0] SignalK,
  output logic [1:0]  SignalX,
  output logic [1:0]  SignalY,
  output logic        rf_write,
  output logic [2:0]  rf_addr,
  output logic [15:0] rf_data,
  output logic        CCR_Write_from_wb,
  output logic [1:0]  CCRWriteValue_from_wb
);

  typedef struct packed {
    logic        valid;
    logic [15:0] ir;
    logic [15:0] alu;
    logic [15:0] pc1;
    logic        ccr_w;
    logic [1:0]  ccr_v;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, ir: 16'h0000, alu: 16'h0000,
                                pc1: 16'h0000, ccr_w: 1'b1, ccr_v: 2'b00};

  stage_t      ex_mem;
  stage_t      mem_wb;
  logic [15:0] mem_wb_data;

  // stall outranks flush; a flush only squashes the incoming EX capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem      <= BUBBLE;
      mem_wb      <= BUBBLE;
      mem_wb_data <= 16'h0000;
    end else if (!stall) begin
      mem_wb      <= ex_mem;
      mem_wb_data <= mem_rdata;
      if (flush) begin
        ex_mem <= BUBBLE;
      end else begin
        ex_mem <= '{valid: in_valid, ir: in_IR, alu: in_ALUOut, pc1: in_PlusOne,
                    ccr_w: in_CCRWrite, ccr_v: in_CCRWriteValue};
      end
    end
  end

  always_comb begin
    ex_mem_op        = 6'b111111;
    ex_mem_regA      = 3'b000;
    ex_mem_regB      = 3'b000;
    ex_mem_regC      = 3'b000;
    ex_mem_CCR_write = 1'b1;
    SignalA          = 16'h0000;
    SignalG          = 16'h0000;
    SignalI          = 16'h0000;
    SignalX          = 2'b00;
    if (ex_mem.valid) begin
      ex_mem_op        = {ex_mem.ir[15:12], ex_mem.ir[1:0]};
      ex_mem_regA      = ex_mem.ir[11:9];
      ex_mem_regB      = ex_mem.ir[8:6];
      ex_mem_regC      = ex_mem.ir[5:3];
      ex_mem_CCR_write = ex_mem.ccr_w;
      SignalA          = ex_mem.alu;
      SignalG          = ex_mem.pc1;
      SignalI          = {ex_mem.ir[8:0], 7'b0000000};
      SignalX          = ex_mem.ccr_v;
    end
  end

  always_comb begin
    mem_wb_op        = 6'b111111;
    mem_wb_regA      = 3'b000;
    mem_wb_regB      = 3'b000;
    mem_wb_regC      = 3'b000;
    mem_wb_CCR_write = 1'b1;
    SignalB          = 16'h0000;
    SignalC          = 16'h0000;
    SignalJ          = 16'h0000;
    SignalK          = 16'h0000;
    SignalY          = 2'b00;
    if (mem_wb.valid) begin
      mem_wb_op        = {mem_wb.ir[15:12], mem_wb.ir[1:0]};
      mem_wb_regA      = mem_wb.ir[11:9];
      mem_wb_regB      = mem_wb.ir[8:6];
      mem_wb_regC      = mem_wb.ir[5:3];
      mem_wb_CCR_write = mem_wb.ccr_w;
      SignalB          = mem_wb.alu;
      SignalC          = mem_wb_data;
      SignalJ          = {mem_wb.ir[8:0], 7'b0000000};
      SignalK          = mem_wb.pc1;
      SignalY          = mem_wb.ccr_v;
    end
  end

  logic       writes_reg;
  logic       flag_gated;
  logic [2:0] dest_reg;

  // arithmetic/logic ops whose CCR write is suppressed also skip the RF write
  always_comb begin
    writes_reg = 1'b0;
    flag_gated = 1'b0;
    dest_reg   = 3'b000;
    rf_data    = SignalB;
    unique case (mem_wb.ir[15:12])
      4'b0000, 4'b0010: begin
        writes_reg = 1'b1;
        flag_gated = 1'b1;
        dest_reg   = mem_wb.ir[5:3];
      end
      4'b0001: begin
        writes_reg = 1'b1;
        flag_gated = 1'b1;
        dest_reg   = mem_wb.ir[8:6];
      end
      4'b0011: begin
        writes_reg = 1'b1;
        dest_reg   = mem_wb.ir[11:9];
        rf_data    = SignalJ;
      end
      4'b0100: begin
        writes_reg = 1'b1;
        dest_reg   = mem_wb.ir[11:9];
        rf_data    = SignalC;
      end
      4'b1000, 4'b1001: begin
        writes_reg = 1'b1;
        dest_reg   = mem_wb.ir[11:9];
        rf_data    = SignalK;
      end
      default: begin
        writes_reg = 1'b0;
      end
    endcase
  end

  assign rf_write = ~(mem_wb.valid && writes_reg && !(flag_gated && mem_wb.ccr_w));
  assign rf_addr  = (mem_wb.valid && writes_reg) ? dest_reg : 3'b000;

  assign CCR_Write_from_wb     = mem_wb_CCR_write;
  assign CCRWriteValue_from_wb = SignalY;

endmodule

// File: tb/tb_wb_forward_stage.sv
// Directed bench for wb_forward_stage: a two-slot pipeline model checked every
// negedge, plus literal expectations at the interesting points.
module tb_wb_forward_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_IR, in_ALUOut, in_PlusOne, mem_rdata;
  logic        in_CCRWrite;
  logic [1:0]  in_CCRWriteValue;
  logic        stall, flush;

  logic [5:0]  ex_mem_op, mem_wb_op;
  logic [2:0]  ex_mem_regA, ex_mem_regB, ex_mem_regC;
  logic [2:0]  mem_wb_regA, mem_wb_regB, mem_wb_regC;
  logic        ex_mem_CCR_write, mem_wb_CCR_write;
  logic [15:0] SignalA, SignalB, SignalC, SignalG, SignalI, SignalJ, SignalK;
  logic [1:0]  SignalX, SignalY;
  logic        rf_write;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic        CCR_Write_from_wb;
  logic [1:0]  CCRWriteValue_from_wb;

  int checks = 0;
  int errors = 0;

  wb_forward_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_IR(in_IR),
    .in_ALUOut(in_ALUOut), .in_PlusOne(in_PlusOne), .in_CCRWrite(in_CCRWrite),
    .in_CCRWriteValue(in_CCRWriteValue), .mem_rdata(mem_rdata),
    .stall(stall), .flush(flush),
    .ex_mem_op(ex_mem_op), .ex_mem_regA(ex_mem_regA), .ex_mem_regB(ex_mem_regB),
    .ex_mem_regC(ex_mem_regC), .ex_mem_CCR_write(ex_mem_CCR_write),
    .mem_wb_op(mem_wb_op), .mem_wb_regA(mem_wb_regA), .mem_wb_regB(mem_wb_regB),
    .mem_wb_regC(mem_wb_regC), .mem_wb_CCR_write(mem_wb_CCR_write),
    .SignalA(SignalA), .SignalB(SignalB), .SignalC(SignalC), .SignalG(SignalG),
    .SignalI(SignalI), .SignalJ(SignalJ), .SignalK(SignalK),
    .SignalX(SignalX), .SignalY(SignalY),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .CCR_Write_from_wb(CCR_Write_from_wb),
    .CCRWriteValue_from_wb(CCRWriteValue_from_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: one record per instruction slot, shifted as a two-entry pipe
  typedef struct {
    bit          v;
    logic [15:0] ir, alu, pc, md;
    bit          cw;
    logic [1:0]  cv;
  } slot_t;

  slot_t m_em, m_mw;
  slot_t empty_slot;

  initial begin
    empty_slot = '{v: 1'b0, ir: 16'h0, alu: 16'h0, pc: 16'h0, md: 16'h0, cw: 1'b1, cv: 2'b0};
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_em <= empty_slot;
      m_mw <= empty_slot;
    end else if (stall !== 1'b1) begin
      m_mw    <= m_em;
      m_mw.md <= mem_rdata;
      if (flush === 1'b1) m_em <= empty_slot;
      else m_em <= '{v: in_valid, ir: in_IR, alu: in_ALUOut, pc: in_PlusOne,
                     md: 16'h0, cw: in_CCRWrite, cv: in_CCRWriteValue};
    end
  end

  // Architectural write-back rule table: destination register or -1
  function automatic int dest_of(input logic [15:0] ir);
    case (ir[15:12])
      4'd0, 4'd2:       return int'(ir[5:3]);
      4'd1:             return int'(ir[8:6]);
      4'd3, 4'd4, 4'd8, 4'd9: return int'(ir[11:9]);
      default:          return -1;
    endcase
  endfunction

  function automatic logic [15:0] wb_value(input slot_t s);
    case (s.ir[15:12])
      4'd4:       return s.md;
      4'd3:       return {s.ir[8:0], 7'd0};
      4'd8, 4'd9: return s.pc;
      default:    return s.alu;
    endcase
  endfunction

  always @(negedge clk) begin
    slot_t e, w;
    bit    exp_wr;
    e = m_em;
    w = m_mw;
    chk("ex_mem_op", 16'(ex_mem_op), e.v ? 16'({e.ir[15:12], e.ir[1:0]}) : 16'h3F);
    chk("ex_mem_regs", 16'({ex_mem_regA, ex_mem_regB, ex_mem_regC}), e.v ? 16'(e.ir[11:3]) : 16'h0);
    chk("ex_mem_ccrw", 16'(ex_mem_CCR_write), e.v ? 16'(e.cw) : 16'h1);
    chk("mem_wb_op", 16'(mem_wb_op), w.v ? 16'({w.ir[15:12], w.ir[1:0]}) : 16'h3F);
    chk("mem_wb_regs", 16'({mem_wb_regA, mem_wb_regB, mem_wb_regC}), w.v ? 16'(w.ir[11:3]) : 16'h0);
    chk("mem_wb_ccrw", 16'(mem_wb_CCR_write), w.v ? 16'(w.cw) : 16'h1);
    chk("SignalA", SignalA, e.v ? e.alu : 16'h0);
    chk("SignalG", SignalG, e.v ? e.pc : 16'h0);
    chk("SignalI", SignalI, e.v ? {e.ir[8:0], 7'd0} : 16'h0);
    chk("SignalX", 16'(SignalX), e.v ? 16'(e.cv) : 16'h0);
    chk("SignalB", SignalB, w.v ? w.alu : 16'h0);
    chk("SignalC", SignalC, w.v ? w.md : 16'h0);
    chk("SignalJ", SignalJ, w.v ? {w.ir[8:0], 7'd0} : 16'h0);
    chk("SignalK", SignalK, w.v ? w.pc : 16'h0);
    chk("SignalY", 16'(SignalY), w.v ? 16'(w.cv) : 16'h0);
    chk("ccr_wb", 16'(CCR_Write_from_wb), w.v ? 16'(w.cw) : 16'h1);
    chk("ccr_val_wb", 16'(CCRWriteValue_from_wb), w.v ? 16'(w.cv) : 16'h0);
    exp_wr = w.v && dest_of(w.ir) >= 0 && !(w.ir[15:12] inside {4'd0, 4'd1, 4'd2} && w.cw);
    chk("rf_write", 16'(rf_write), 16'(!exp_wr));
    if (exp_wr) begin
      chk("rf_addr", 16'(rf_addr), 16'(dest_of(w.ir)));
      chk("rf_data", rf_data, wb_value(w));
    end
  end

  task automatic step(input bit v, input logic [15:0] ir, input logic [15:0] alu,
                      input logic [15:0] pc, input bit cw, input logic [1:0] cv,
                      input logic [15:0] rd, input bit st, input bit fl);
    in_valid = v; in_IR = ir; in_ALUOut = alu; in_PlusOne = pc;
    in_CCRWrite = cw; in_CCRWriteValue = cv; mem_rdata = rd; stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct { logic [15:0] ir, alu; bit cw; logic [15:0] rd; } vec_t;
  vec_t mix [6];

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_IR = 16'h0; in_ALUOut = 16'h0; in_PlusOne = 16'h0;
    in_CCRWrite = 1'b1; in_CCRWriteValue = 2'b0; mem_rdata = 16'h0;
    stall = 1'b0; flush = 1'b0;
    #2;
    chk("rst_rf_write", 16'(rf_write), 16'h1);
    chk("rst_ex_mem_op", 16'(ex_mem_op), 16'h3F);
    chk("rst_SignalK", SignalK, 16'h0);
    @(negedge clk);
    reset = 1'b1;

    step(1, 16'h0298, 16'h0005, 16'h0011, 0, 2'b01, 16'h0, 0, 0);   // ADD r3,r1,r2
    chk("add_e1_SignalA", SignalA, 16'h0005);
    chk("add_e1_regC", 16'(ex_mem_regC), 16'h3);
    step(1, 16'h4800, 16'h0020, 16'h0012, 1, 2'b00, 16'h0, 0, 0);   // LW r4
    chk("add_e2_SignalB", SignalB, 16'h0005);
    chk("add_e2_rf_write", 16'(rf_write), 16'h0);
    chk("add_e2_rf_addr", 16'(rf_addr), 16'h3);
    chk("add_e2_rf_data", rf_data, 16'h0005);
    chk("add_e2_ccr_wb", 16'(CCR_Write_from_wb), 16'h0);
    step(1, 16'h35FF, 16'h1234, 16'h0013, 1, 2'b00, 16'hBEEF, 0, 0); // LHI r2
    chk("lw_SignalC", SignalC, 16'hBEEF);
    chk("lw_rf_addr", 16'(rf_addr), 16'h4);
    chk("lw_rf_data", rf_data, 16'hBEEF);
    chk("lhi_SignalI", SignalI, 16'hFF80);
    step(1, 16'h02AA, 16'h0007, 16'h0014, 1, 2'b10, 16'h0, 0, 0);   // ADC, flag write suppressed
    chk("lhi_SignalJ", SignalJ, 16'hFF80);
    chk("lhi_rf_data", rf_data, 16'hFF80);
    chk("lhi_rf_addr", 16'(rf_addr), 16'h2);
    step(1, 16'h8C05, 16'h0099, 16'h0015, 1, 2'b00, 16'h0, 0, 0);   // JAL r6
    chk("adc_rf_write", 16'(rf_write), 16'h1);
    chk("adc_ccr_wb", 16'(CCR_Write_from_wb), 16'h1);
    for (int i = 0; i < 2; i++) begin
      step(1, 16'h0298, 16'hAAAA, 16'h0100, 0, 2'b11, 16'h5555, 1, 0);
      chk("stall_SignalA", SignalA, 16'h0099);
      chk("stall_SignalB", SignalB, 16'h0007);
      chk("stall_ex_op", 16'(ex_mem_op), 16'h21);
      chk("stall_wb_op", 16'(mem_wb_op), 16'h02);
    end
    step(1, 16'h1303, 16'h0042, 16'h0016, 0, 2'b01, 16'h0, 0, 0);   // ADI r4
    chk("jal_rf_addr", 16'(rf_addr), 16'h6);
    chk("jal_rf_data", rf_data, 16'h0015);
    step(1, 16'h0298, 16'h0009, 16'h0017, 0, 2'b00, 16'h0, 0, 1);   // flushed ADD
    chk("flush_ex_op", 16'(ex_mem_op), 16'h3F);
    chk("flush_SignalA", SignalA, 16'h0);
    chk("flush_wb_op", 16'(mem_wb_op), 16'h07);
    chk("flush_rf_addr", 16'(rf_addr), 16'h4);
    chk("flush_rf_data", rf_data, 16'h0042);
    step(1, 16'h0298, 16'h0009, 16'h0017, 0, 2'b00, 16'h0, 1, 1);   // stall beats flush
    chk("stflush_wb_op", 16'(mem_wb_op), 16'h07);

    // reset in mid-flight
    step(1, 16'h0298, 16'h0005, 16'h0018, 0, 2'b00, 16'h0, 0, 0);
    step(0, 16'h0000, 16'h0000, 16'h0000, 1, 2'b00, 16'h0, 0, 0);
    chk("pre_rst_rf_write", 16'(rf_write), 16'h0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_rf_write", 16'(rf_write), 16'h1);
    chk("async_rst_ex_op", 16'(ex_mem_op), 16'h3F);
    chk("async_rst_SignalB", SignalB, 16'h0);
    step(1, 16'h4800, 16'h0001, 16'h0019, 1, 2'b00, 16'h0, 0, 0);
    chk("in_rst_ex_op", 16'(ex_mem_op), 16'h3F);
    reset = 1'b1;
    step(1, 16'h4800, 16'h0001, 16'h0019, 1, 2'b00, 16'h0, 0, 0);
    chk("post_rst_ex_op", 16'(ex_mem_op), 16'h10);
    chk("post_rst_wb_op", 16'(mem_wb_op), 16'h3F);

    // mixed opcodes, checked by the model only
    mix[0] = '{ir: 16'h2A79, alu: 16'h0F0F, cw: 0, rd: 16'h1111}; // NDZ
    mix[1] = '{ir: 16'hC283, alu: 16'h0001, cw: 1, rd: 16'h2222}; // BEQ
    mix[2] = '{ir: 16'h9A40, alu: 16'h0003, cw: 1, rd: 16'h3333}; // JLR r5
    mix[3] = '{ir: 16'h5E01, alu: 16'h0004, cw: 1, rd: 16'h4444}; // SW
    mix[4] = '{ir: 16'h1FC1, alu: 16'h8000, cw: 1, rd: 16'h5555}; // ADI suppressed
    mix[5] = '{ir: 16'h4200, alu: 16'h0006, cw: 1, rd: 16'hCAFE}; // LW r1
    for (int i = 0; i < 6; i++)
      step(1, mix[i].ir, mix[i].alu, 16'(16'h0200 + i), mix[i].cw, 2'(i), mix[i].rd, 0, 0);
    step(0, 16'h0, 16'h0, 16'h0, 1, 2'b00, 16'h7777, 0, 0);
    step(0, 16'h0, 16'h0, 16'h0, 1, 2'b00, 16'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
